// File: rtl/perf_pkg.sv
// Shared types for the performance-counter bank: dump FSM states, drop-counter
// width and the record layout a dump consumer sees.
package perf_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam int DROP_W = 16;

  // Record fields sized for the widest legal configuration.
  localparam int REC_IDX_W   = 6;
  localparam int REC_VAL_W   = 64;
  localparam int REC_TIMER_W = 64;

  typedef struct packed {
    logic [REC_IDX_W-1:0]   idx;
    logic [REC_VAL_W-1:0]   value;
    logic                   ovf;
    logic [REC_TIMER_W-1:0] timer;
    logic                   last;
  } perf_rec_t;

endpackage

// File: rtl/perf_counter_ch.sv
// One event-counter channel: wrapping accumulator with a sticky carry-out flag.
module perf_counter_ch
  import perf_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int INC_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clean,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc);
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clean) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      cnt_d = sum[CNT_W-1:0];
      ovf_d = ovf_q | sum[CNT_W];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Multi-channel performance-counter bank: counts events, snapshots all channels
// plus the timer on a dump edge, and streams one record per channel.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter  int NUM_CH  = 8,
  parameter  int CNT_W   = 64,
  parameter  int INC_W   = 4,
  parameter  int TIMER_W = 64,
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*INC_W-1:0] inc,
  input  logic                    log_enable,
  input  logic                    clean,
  input  logic                    dump,
  input  logic [TIMER_W-1:0]      timer,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic [CNT_W-1:0]        out_value,
  output logic                    out_ovf,
  output logic [TIMER_W-1:0]      out_timer,
  output logic                    out_last,
  output logic                    busy,
  output logic [DROP_W-1:0]       dump_dropped
);

  logic [CNT_W-1:0] cnt [NUM_CH];
  logic             ovf [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      perf_counter_ch #(.CNT_W(CNT_W), .INC_W(INC_W)) u_ch (
        .clock (clock),
        .reset (reset),
        .en    (log_enable),
        .clean (clean),
        .inc   (inc[gi*INC_W +: INC_W]),
        .cnt   (cnt[gi]),
        .ovf   (ovf[gi])
      );
    end
  endgenerate

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
  logic [CNT_W-1:0]   snap_q [NUM_CH];
  logic [CNT_W-1:0]   snap_d [NUM_CH];
  logic               snap_ovf_q [NUM_CH];
  logic               snap_ovf_d [NUM_CH];
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   val_q, val_d;
  logic               rec_ovf_q, rec_ovf_d;
  logic               last_q, last_d;
  logic               dump_prev_q;
  logic [DROP_W-1:0]  dropped_q, dropped_d;
  logic               dump_req, hs;

  always_comb begin
    dump_req   = dump & ~dump_prev_q;
    hs         = (state_q == STREAM) & out_ready;
    idx_nxt    = idx_q + IDX_W'(1);
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    snap_ovf_d = snap_ovf_q;
    timer_d    = timer_q;
    val_d      = val_q;
    rec_ovf_d  = rec_ovf_q;
    last_d     = last_q;
    dropped_d  = dropped_q;
    case (state_q)
      IDLE: begin
        // Record 0 is loaded straight from the live counters so it is valid next cycle.
        if (dump_req) begin
          snap_d     = cnt;
          snap_ovf_d = ovf;
          timer_d    = timer;
          val_d      = cnt[0];
          rec_ovf_d  = ovf[0];
          last_d     = (NUM_CH == 1);
          idx_d      = '0;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (dump_req && (dropped_q != '1)) dropped_d = dropped_q + DROP_W'(1);
        if (hs) begin
          if (last_q) begin
            state_d = IDLE;
            idx_d   = '0;
            last_d  = 1'b0;
          end else begin
            idx_d     = idx_nxt;
            val_d     = snap_q[idx_nxt];
            rec_ovf_d = snap_ovf_q[idx_nxt];
            last_d    = (idx_nxt == IDX_W'(NUM_CH - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i]     <= '0;
        snap_ovf_q[i] <= 1'b0;
      end
      timer_q     <= '0;
      val_q       <= '0;
      rec_ovf_q   <= 1'b0;
      last_q      <= 1'b0;
      dump_prev_q <= 1'b0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      snap_ovf_q  <= snap_ovf_d;
      timer_q     <= timer_d;
      val_q       <= val_d;
      rec_ovf_q   <= rec_ovf_d;
      last_q      <= last_d;
      dump_prev_q <= dump;
      dropped_q   <= dropped_d;
    end
  end

  assign out_valid    = (state_q == STREAM);
  assign busy         = (state_q == STREAM);
  assign out_idx      = idx_q;
  assign out_value    = val_q;
  assign out_ovf      = rec_ovf_q;
  assign out_timer    = timer_q;
  assign out_last     = last_q;
  assign dump_dropped = dropped_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: per-cycle reference model feeding a
// record scoreboard, a vector table of counting phases, and directed corner sequences.
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int NUM_CH  = 8;
  localparam int CNT_W   = 16;
  localparam int INC_W   = 4;
  localparam int TIMER_W = 64;
  localparam int IDX_W   = 3;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [NUM_CH*INC_W-1:0] inc = '0;
  logic                    log_enable = 1'b0;
  logic                    clean = 1'b0;
  logic                    dump = 1'b0;
  logic [TIMER_W-1:0]      timer = '0;
  logic                    out_ready = 1'b0;
  logic                    out_valid;
  logic [IDX_W-1:0]        out_idx;
  logic [CNT_W-1:0]        out_value;
  logic                    out_ovf;
  logic [TIMER_W-1:0]      out_timer;
  logic                    out_last;
  logic                    busy;
  logic [15:0]             dump_dropped;

  perf_counter_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .INC_W(INC_W), .TIMER_W(TIMER_W)
  ) dut (
    .clock(clock), .reset(reset), .inc(inc), .log_enable(log_enable),
    .clean(clean), .dump(dump), .timer(timer), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_value(out_value),
    .out_ovf(out_ovf), .out_timer(out_timer), .out_last(out_last),
    .busy(busy), .dump_dropped(dump_dropped)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference model and scoreboard, evaluated on the falling edge.
  logic [CNT_W-1:0] m_cnt [NUM_CH];
  logic             m_ovf [NUM_CH];
  logic             m_prev = 1'b0;
  int               m_remain = 0;
  int               m_dropped = 0;
  perf_rec_t        exp_q [$];
  int               hs_count = 0;
  logic             stall_prev = 1'b0;
  logic [63:0]      held = '0;
  logic [CNT_W-1:0] got_val [NUM_CH];
  logic             got_ovf [NUM_CH];

  always @(negedge clock) begin
    perf_rec_t   e;
    logic        req;
    logic [CNT_W:0] s;
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = '0;
        m_ovf[i] = 1'b0;
      end
      m_prev = 1'b0;
      m_remain = 0;
      m_dropped = 0;
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      check("busy", 64'(busy), 64'(m_remain > 0));
      check("out_valid", 64'(out_valid), 64'(m_remain > 0));
      check("dump_dropped", 64'(dump_dropped), 64'(m_dropped));
      if (stall_prev) check("held_record", 64'({out_idx, out_ovf, out_last, out_value}), held);
      stall_prev = out_valid && !out_ready;
      held = 64'({out_idx, out_ovf, out_last, out_value});

      req = dump && !m_prev;
      if (req) begin
        if (m_remain == 0) begin
          for (int i = 0; i < NUM_CH; i++) begin
            e.idx   = REC_IDX_W'(i);
            e.value = REC_VAL_W'(m_cnt[i]);
            e.ovf   = m_ovf[i];
            e.timer = REC_TIMER_W'(timer);
            e.last  = (i == NUM_CH - 1);
            exp_q.push_back(e);
          end
          m_remain = NUM_CH;
        end else if (m_dropped < 65535) begin
          m_dropped++;
        end
      end
      m_prev = dump;

      if (out_valid && out_ready) begin
        hs_count++;
        if (m_remain > 0) m_remain--;
        if (exp_q.size() == 0) begin
          check("unexpected_record", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rec_idx",   64'(out_idx),   64'(e.idx));
          check("rec_value", 64'(out_value), e.value);
          check("rec_ovf",   64'(out_ovf),   64'(e.ovf));
          check("rec_timer", out_timer,      e.timer);
          check("rec_last",  64'(out_last),  64'(e.last));
          got_val[out_idx] = out_value;
          got_ovf[out_idx] = out_ovf;
        end
      end

      for (int i = 0; i < NUM_CH; i++) begin
        if (clean) begin
          m_cnt[i] = '0;
          m_ovf[i] = 1'b0;
        end else if (log_enable) begin
          s = {1'b0, m_cnt[i]} + (CNT_W+1)'(inc[i*INC_W +: INC_W]);
          m_cnt[i] = s[CNT_W-1:0];
          m_ovf[i] = m_ovf[i] | s[CNT_W];
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_got();
    for (int i = 0; i < NUM_CH; i++) begin
      got_val[i] = '1;
      got_ovf[i] = 1'b1;
    end
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy && k < 200) begin
      step(1);
      k++;
    end
    check("wait_idle_timeout", 64'(busy), 64'(0));
  endtask

  // Full-speed dump: request, stream, and confirm eight back-to-back records.
  task automatic do_dump(input logic [63:0] t);
    int k;
    int hs0;
    clear_got();
    hs0 = hs_count;
    timer = t;
    out_ready = 1'b1;
    dump = 1'b1;
    step(1);
    dump = 1'b0;
    check("first_record_latency", 64'(out_valid), 64'(1));
    wait_idle(k);
    check("stream_cycles", 64'(k), 64'(NUM_CH));
    check("dump_records", 64'(hs_count - hs0), 64'(NUM_CH));
  endtask

  typedef struct {
    logic [31:0] inc_v;
    bit          en;
    bit          cln;
    int          cycles;
    logic [63:0] tval;
    int          exp_c0;
    int          exp_c2;
  } vec_t;

  vec_t vecs [5];
  bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int k;
    int hs0;
    int dseq [8];

    // Cumulative counter values after each phase are worked out by hand.
    vecs[0] = '{32'h0000_0300, 1'b1, 1'b0, 10, 64'd1000, 0, 30};
    vecs[1] = '{32'h1234_5678, 1'b1, 1'b0, 7,  64'd2000, 56, 72};
    vecs[2] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 5,  64'd3000, 56, 72};
    vecs[3] = '{32'hF0F0_0F0F, 1'b1, 1'b1, 3,  64'd4000, 0, 0};
    vecs[4] = '{32'h8765_4321, 1'b1, 1'b0, 4,  64'd5000, 4, 12};

    step(3);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_idx", 64'(out_idx), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_out_timer", out_timer, 64'(0));
    check("rst_dump_dropped", 64'(dump_dropped), 64'(0));
    reset = 1'b1;
    step(1);

    for (int v = 0; v < 5; v++) begin
      inc = vecs[v].inc_v;
      log_enable = vecs[v].en;
      clean = vecs[v].cln;
      step(vecs[v].cycles);
      inc = '0;
      clean = 1'b0;
      log_enable = 1'b1;
      do_dump(vecs[v].tval);
      check($sformatf("vec%0d_ch0", v), 64'(got_val[0]), 64'(vecs[v].exp_c0));
      check($sformatf("vec%0d_ch2", v), 64'(got_val[2]), 64'(vecs[v].exp_c2));
      if (v == 0) begin
        for (int i = 0; i < NUM_CH; i++)
          if (i != 2) check($sformatf("vec0_ch%0d_zero", i), 64'(got_val[i]), 64'(0));
        check("vec0_timer", out_timer, 64'd1000);
      end
    end

    // Overflow: bring ch0 to 2^CNT_W-2, then add 5.
    clean = 1'b1; step(1); clean = 1'b0;
    log_enable = 1'b1;
    inc = 32'h0000_000F; step(4368);
    inc = 32'h0000_000E; step(1);
    inc = 32'h0000_0005; step(1);
    inc = '0;
    do_dump(64'd6000);
    check("ovf_wrap_value", 64'(got_val[0]), 64'(3));
    check("ovf_sticky", 64'(got_ovf[0]), 64'(1));
    check("ovf_other_ch", 64'(got_ovf[1]), 64'(0));
    clean = 1'b1; step(1); clean = 1'b0;
    do_dump(64'd6100);
    check("clean_value", 64'(got_val[0]), 64'(0));
    check("clean_ovf", 64'(got_ovf[0]), 64'(0));

    // Clean and dump request in the same cycle: snapshot keeps pre-clean values.
    inc = 32'h0000_0070; step(1); inc = '0;
    clear_got();
    out_ready = 1'b1;
    timer = 64'd6500;
    clean = 1'b1; dump = 1'b1;
    step(1);
    clean = 1'b0; dump = 1'b0;
    wait_idle(k);
    check("clean_dump_snap_ch1", 64'(got_val[1]), 64'(7));
    do_dump(64'd6600);
    check("clean_dump_after_ch1", 64'(got_val[1]), 64'(0));

    // Back-pressure: out_ready follows 1,0,0,1,0,1,...
    inc = 32'h8765_4321; step(2); inc = '0;
    clear_got();
    hs0 = hs_count;
    timer = 64'd7000;
    out_ready = 1'b0;
    dump = 1'b1; step(1); dump = 1'b0;
    k = 0;
    while (busy && k < 60) begin
      out_ready = pat[k % 6];
      step(1);
      k++;
    end
    out_ready = 1'b1;
    check("stall_timeout", 64'(busy), 64'(0));
    check("stall_handshakes", 64'(hs_count - hs0), 64'(NUM_CH));
    check("stall_ch7", 64'(got_val[7]), 64'(16));

    // Three dump edges during one stream, then a request right after the last handshake.
    dseq = '{0, 1, 0, 1, 0, 1, 0, 0};
    hs0 = hs_count;
    timer = 64'd8000;
    out_ready = 1'b1;
    dump = 1'b1; step(1);
    for (int i = 0; i < 8; i++) begin
      dump = dseq[i][0];
      step(1);
    end
    check("drop_busy_after_stream", 64'(busy), 64'(0));
    check("drop_count", 64'(dump_dropped), 64'(3));
    check("drop_one_stream", 64'(hs_count - hs0), 64'(NUM_CH));
    dump = 1'b1; step(1); dump = 1'b0;
    check("back_to_back_accept", 64'(busy), 64'(1));
    wait_idle(k);
    check("back_to_back_records", 64'(hs_count - hs0), 64'(2 * NUM_CH));

    // Reset while streaming record 3, with dump held high across the release.
    log_enable = 1'b1;
    inc = 32'h1111_1111; step(3); inc = '0;
    out_ready = 1'b1;
    timer = 64'd9000;
    dump = 1'b1; step(1); dump = 1'b0;
    k = 0;
    while (out_idx != 3'd3 && k < 20) begin
      step(1);
      k++;
    end
    check("reach_idx3", 64'(out_idx), 64'(3));
    hs0 = hs_count;
    reset = 1'b0;
    dump = 1'b1;
    step(1);
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    step(4);
    check("midrst_no_records", 64'(hs_count - hs0), 64'(0));
    check("midrst_dropped", 64'(dump_dropped), 64'(0));
    clear_got();
    reset = 1'b1;
    step(1);
    check("dump_across_reset", 64'(busy), 64'(1));
    dump = 1'b0;
    wait_idle(k);
    check("post_reset_records", 64'(hs_count - hs0), 64'(NUM_CH));
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("post_reset_ch%0d", i), 64'(got_val[i]), 64'(0));

    step(2);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
